// File: rtl/bus_arbiter_pkg.sv
// Shared constants and state encoding for the instruction/data bus arbiter.
package bus_arbiter_pkg;

  localparam int unsigned BUS_W = 32;
  localparam logic [3:0]  SEL_FULL = 4'b1111;

  // Arbiter sequencing states; the numeric codes are visible on dbg_state_o.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_D_BUSY = 3'd1,
    ST_I_BUSY = 3'd2,
    ST_D_DONE = 3'd3,
    ST_I_DONE = 3'd4,
    ST_I_DROP = 3'd5
  } state_t;

endpackage

// File: rtl/bus_timeout_cnt.sv
// Bus wait counter: cleared on each grant, counts BUSY cycles without ack,
// and flags the cycle in which the count reaches LIMIT.
module bus_timeout_cnt #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned W = (LIMIT < 2) ? 1 : $clog2(LIMIT);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] cnt;

  // Wait counter; the increment that would reach LIMIT is the expiry cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + W'(1);
    end
  end

  assign expired = en & (cnt == LAST);

endmodule

// File: rtl/bus_arbiter.sv
// Single-port bus arbiter between fetch (ibus) and load/store (dbus).
// Data has priority; every access passes through IDLE between grants.
// Optional wait timeout is built only when BUS_TIMEOUT_EN is defined.
//
// Handshake: bus_req_o rises the cycle after a grant and stays high, with
// all bus_* fields stable, until the cycle in which bus_ack_i is sampled
// high (or the timeout expires); ack outside BUSY is ignored.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ibus_ce_i,
  input  logic [BUS_W-1:0] ibus_addr_i,
  output logic [BUS_W-1:0] ibus_data_o,
  output logic             ibus_stallreq_o,
  input  logic             dbus_ce_i,
  input  logic             dbus_we_i,
  input  logic [3:0]       dbus_sel_i,
  input  logic [BUS_W-1:0] dbus_addr_i,
  input  logic [BUS_W-1:0] dbus_data_i,
  output logic [BUS_W-1:0] dbus_data_o,
  output logic             dbus_stallreq_o,
  input  logic             flush_i,
  output logic             bus_req_o,
  output logic             bus_we_o,
  output logic [3:0]       bus_sel_o,
  output logic [BUS_W-1:0] bus_addr_o,
  output logic [BUS_W-1:0] bus_data_o,
  input  logic [BUS_W-1:0] bus_data_i,
  input  logic             bus_ack_i,
  output logic             bus_err_o,
  output logic [2:0]       dbg_state_o
);

  state_t           state;
  logic             lat_we;
  logic [3:0]       lat_sel;
  logic [BUS_W-1:0] lat_addr;
  logic [BUS_W-1:0] lat_data;
  logic [BUS_W-1:0] i_result;
  logic [BUS_W-1:0] d_result;
  logic             flushed;
  logic             req_q;
  logic             err_q;
  logic             busy;
  logic             expired;

  assign busy = (state == ST_D_BUSY) || (state == ST_I_BUSY);

`ifdef BUS_TIMEOUT_EN
  // Counter is held clear in IDLE, so it always starts from zero on a grant.
  bus_timeout_cnt #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (state == ST_IDLE),
    .en      (busy & ~bus_ack_i),
    .expired (expired)
  );
`else
  // No timeout hardware: BUSY waits for ack indefinitely.
  assign expired = (TIMEOUT_CYCLES == 0) & 1'b0;
`endif

  // Arbitration/sequencing FSM with registered bus fields and results.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      lat_we   <= 1'b0;
      lat_sel  <= '0;
      lat_addr <= '0;
      lat_data <= '0;
      i_result <= '0;
      d_result <= '0;
      flushed  <= 1'b0;
      req_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (dbus_ce_i) begin
            lat_addr <= dbus_addr_i;
            lat_we   <= dbus_we_i;
            lat_sel  <= dbus_sel_i;
            lat_data <= dbus_data_i;
            req_q    <= 1'b1;
            state    <= ST_D_BUSY;
          end else if (ibus_ce_i) begin
            lat_addr <= ibus_addr_i;
            lat_we   <= 1'b0;
            lat_sel  <= SEL_FULL;
            flushed  <= 1'b0;
            req_q    <= 1'b1;
            state    <= ST_I_BUSY;
          end
        end
        ST_D_BUSY: begin
          // Data accesses are never flushed; they always run to completion.
          if (bus_ack_i) begin
            d_result <= bus_data_i;
            req_q    <= 1'b0;
            state    <= ST_D_DONE;
          end else if (expired) begin
            d_result <= '0;
            req_q    <= 1'b0;
            err_q    <= 1'b1;
            state    <= ST_D_DONE;
          end
        end
        ST_I_BUSY: begin
          // A flush anywhere in the access turns its result into a drop.
          flushed <= flushed | flush_i;
          if (bus_ack_i || expired) begin
            req_q <= 1'b0;
            err_q <= ~bus_ack_i;
            if (flushed || flush_i) begin
              state <= ST_I_DROP;
            end else begin
              i_result <= bus_ack_i ? bus_data_i : '0;
              state    <= ST_I_DONE;
            end
          end
        end
        ST_D_DONE, ST_I_DONE, ST_I_DROP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          req_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus_req_o       = req_q;
  assign bus_we_o        = lat_we;
  assign bus_sel_o       = lat_sel;
  assign bus_addr_o      = lat_addr;
  assign bus_data_o      = lat_data;
  assign bus_err_o       = err_q;
  assign ibus_data_o     = i_result;
  assign dbus_data_o     = d_result;
  assign dbus_stallreq_o = dbus_ce_i & (state != ST_D_DONE);
  assign ibus_stallreq_o = ibus_ce_i & (state != ST_I_DONE);
  assign dbg_state_o     = state;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter. Each cycle: inputs driven 1ns after the
// rising edge, outputs sampled 1ns later. Timeout case needs BUS_TIMEOUT_EN.
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ibus_ce_i = 1'b0;
  logic [31:0] ibus_addr_i = '0;
  logic [31:0] ibus_data_o;
  logic        ibus_stallreq_o;
  logic        dbus_ce_i = 1'b0;
  logic        dbus_we_i = 1'b0;
  logic [3:0]  dbus_sel_i = '0;
  logic [31:0] dbus_addr_i = '0;
  logic [31:0] dbus_data_i = '0;
  logic [31:0] dbus_data_o;
  logic        dbus_stallreq_o;
  logic        flush_i = 1'b0;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_data_o;
  logic [31:0] bus_data_i = '0;
  logic        bus_ack_i = 1'b0;
  logic        bus_err_o;
  logic [2:0]  dbg_state_o;

  int checks = 0;
  int errors = 0;

  bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .ibus_ce_i       (ibus_ce_i),
    .ibus_addr_i     (ibus_addr_i),
    .ibus_data_o     (ibus_data_o),
    .ibus_stallreq_o (ibus_stallreq_o),
    .dbus_ce_i       (dbus_ce_i),
    .dbus_we_i       (dbus_we_i),
    .dbus_sel_i      (dbus_sel_i),
    .dbus_addr_i     (dbus_addr_i),
    .dbus_data_i     (dbus_data_i),
    .dbus_data_o     (dbus_data_o),
    .dbus_stallreq_o (dbus_stallreq_o),
    .flush_i         (flush_i),
    .bus_req_o       (bus_req_o),
    .bus_we_o        (bus_we_o),
    .bus_sel_o       (bus_sel_o),
    .bus_addr_o      (bus_addr_o),
    .bus_data_o      (bus_data_o),
    .bus_data_i      (bus_data_i),
    .bus_ack_i       (bus_ack_i),
    .bus_err_o       (bus_err_o),
    .dbg_state_o     (dbg_state_o)
  );

  // Clock: 10ns period.
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  initial begin
    // Reset state.
    tick();
    settle();
    check("rst_state", 32'(dbg_state_o), 32'd0);
    check("rst_req", 32'(bus_req_o), 32'd0);
    check("rst_addr", bus_addr_o, 32'h0);
    check("rst_sel", 32'(bus_sel_o), 32'h0);
    check("rst_idata", ibus_data_o, 32'h0);
    check("rst_ddata", dbus_data_o, 32'h0);
    check("rst_err", 32'(bus_err_o), 32'd0);
    rst = 1'b1;

    // Fetch only, zero-wait ack.
    tick();
    ibus_ce_i = 1'b1; ibus_addr_i = 32'h0000_0040;
    settle();
    check("f1_c0_stall", 32'(ibus_stallreq_o), 32'd1);
    check("f1_c0_req", 32'(bus_req_o), 32'd0);
    tick();
    bus_ack_i = 1'b1; bus_data_i = 32'h2401_0005;
    settle();
    check("f1_c1_req", 32'(bus_req_o), 32'd1);
    check("f1_c1_addr", bus_addr_o, 32'h0000_0040);
    check("f1_c1_sel", 32'(bus_sel_o), 32'hF);
    check("f1_c1_we", 32'(bus_we_o), 32'd0);
    check("f1_c1_stall", 32'(ibus_stallreq_o), 32'd1);
    tick();
    bus_ack_i = 1'b0; bus_data_i = '0;
    settle();
    check("f1_c2_state", 32'(dbg_state_o), 32'd4);
    check("f1_c2_stall", 32'(ibus_stallreq_o), 32'd0);
    check("f1_c2_req", 32'(bus_req_o), 32'd0);
    check("f1_c2_data", ibus_data_o, 32'h2401_0005);
    tick();
    ibus_ce_i = 1'b0;
    settle();
    check("f1_c3_state", 32'(dbg_state_o), 32'd0);

    // Ack while idle must be ignored.
    bus_ack_i = 1'b1; bus_data_i = 32'h5555_5555;
    tick();
    bus_ack_i = 1'b0; bus_data_i = '0;
    settle();
    check("idle_ack_state", 32'(dbg_state_o), 32'd0);
    check("idle_ack_ddata", dbus_data_o, 32'h0);
    check("idle_ack_idata", ibus_data_o, 32'h2401_0005);

    // Simultaneous store and fetch: data first.
    dbus_ce_i = 1'b1; dbus_we_i = 1'b1; dbus_sel_i = 4'b0100;
    dbus_addr_i = 32'h0000_0100; dbus_data_i = 32'hABAB_ABAB;
    ibus_ce_i = 1'b1; ibus_addr_i = 32'h0000_0044;
    settle();
    check("both_c0_dstall", 32'(dbus_stallreq_o), 32'd1);
    check("both_c0_istall", 32'(ibus_stallreq_o), 32'd1);
    tick();
    bus_ack_i = 1'b1; bus_data_i = 32'h0;
    settle();
    check("both_c1_state", 32'(dbg_state_o), 32'd1);
    check("both_c1_we", 32'(bus_we_o), 32'd1);
    check("both_c1_sel", 32'(bus_sel_o), 32'h4);
    check("both_c1_addr", bus_addr_o, 32'h0000_0100);
    check("both_c1_wdata", bus_data_o, 32'hABAB_ABAB);
    check("both_c1_istall", 32'(ibus_stallreq_o), 32'd1);
    tick();
    bus_ack_i = 1'b0;
    settle();
    check("both_c2_dstall", 32'(dbus_stallreq_o), 32'd0);
    check("both_c2_istall", 32'(ibus_stallreq_o), 32'd1);
    tick();
    dbus_ce_i = 1'b0; dbus_we_i = 1'b0;
    settle();
    check("both_c3_req", 32'(bus_req_o), 32'd0);
    check("both_c3_istall", 32'(ibus_stallreq_o), 32'd1);
    tick();
    bus_ack_i = 1'b1; bus_data_i = 32'h1111_2222;
    settle();
    check("both_c4_state", 32'(dbg_state_o), 32'd2);
    check("both_c4_addr", bus_addr_o, 32'h0000_0044);
    check("both_c4_we", 32'(bus_we_o), 32'd0);
    check("both_c4_istall", 32'(ibus_stallreq_o), 32'd1);
    tick();
    bus_ack_i = 1'b0; bus_data_i = '0;
    settle();
    check("both_c5_istall", 32'(ibus_stallreq_o), 32'd0);
    check("both_c5_idata", ibus_data_o, 32'h1111_2222);
    tick();
    ibus_ce_i = 1'b0;

    // Load with three wait cycles.
    dbus_ce_i = 1'b1; dbus_we_i = 1'b0; dbus_sel_i = 4'b1111;
    dbus_addr_i = 32'h0000_0200; dbus_data_i = 32'h0;
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        bus_ack_i = 1'b1; bus_data_i = 32'hDEAD_BEEF;
      end
      dbus_addr_i = 32'h0000_0F00;
      settle();
      check($sformatf("ld_w%0d_req", i), 32'(bus_req_o), 32'd1);
      check($sformatf("ld_w%0d_addr", i), bus_addr_o, 32'h0000_0200);
      check($sformatf("ld_w%0d_dstall", i), 32'(dbus_stallreq_o), 32'd1);
      tick();
    end
    bus_ack_i = 1'b0; bus_data_i = '0;
    settle();
    check("ld_done_state", 32'(dbg_state_o), 32'd3);
    check("ld_done_data", dbus_data_o, 32'hDEAD_BEEF);
    check("ld_done_dstall", 32'(dbus_stallreq_o), 32'd0);
    tick();
    dbus_ce_i = 1'b0;

    // Flushed fetch: result dropped, stall held.
    ibus_ce_i = 1'b1; ibus_addr_i = 32'h0000_0080;
    tick();
    flush_i = 1'b1;
    settle();
    check("fl_c1_state", 32'(dbg_state_o), 32'd2);
    check("fl_c1_istall", 32'(ibus_stallreq_o), 32'd1);
    tick();
    flush_i = 1'b0;
    settle();
    check("fl_c2_istall", 32'(ibus_stallreq_o), 32'd1);
    tick();
    bus_ack_i = 1'b1; bus_data_i = 32'h9999_9999;
    settle();
    check("fl_c3_istall", 32'(ibus_stallreq_o), 32'd1);
    tick();
    bus_ack_i = 1'b0; bus_data_i = '0;
    settle();
    check("fl_c4_state", 32'(dbg_state_o), 32'd5);
    check("fl_c4_istall", 32'(ibus_stallreq_o), 32'd1);
    check("fl_c4_idata", ibus_data_o, 32'h1111_2222);
    tick();
    ibus_ce_i = 1'b0;
    settle();
    check("fl_c5_state", 32'(dbg_state_o), 32'd0);
    check("fl_c5_idata", ibus_data_o, 32'h1111_2222);

    // Reset in the middle of a store.
    dbus_ce_i = 1'b1; dbus_we_i = 1'b1; dbus_sel_i = 4'b0011;
    dbus_addr_i = 32'h0000_0300; dbus_data_i = 32'h1234_5678;
    tick();
    settle();
    check("rs_busy_req", 32'(bus_req_o), 32'd1);
    dbus_ce_i = 1'b0;
    rst = 1'b0;
    settle();
    check("rs_req", 32'(bus_req_o), 32'd0);
    check("rs_we", 32'(bus_we_o), 32'd0);
    check("rs_addr", bus_addr_o, 32'h0);
    check("rs_wdata", bus_data_o, 32'h0);
    check("rs_idata", ibus_data_o, 32'h0);
    check("rs_ddata", dbus_data_o, 32'h0);
    check("rs_dstall", 32'(dbus_stallreq_o), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    settle();
    check("rs_after_state", 32'(dbg_state_o), 32'd0);
    check("rs_after_req", 32'(bus_req_o), 32'd0);

`ifdef BUS_TIMEOUT_EN
    // No ack: four request cycles, then error pulse with zero result.
    dbus_ce_i = 1'b1; dbus_we_i = 1'b0; dbus_sel_i = 4'b1111;
    dbus_addr_i = 32'h0000_0400;
    tick();
    for (int i = 0; i < 4; i++) begin
      settle();
      check($sformatf("to_w%0d_req", i), 32'(bus_req_o), 32'd1);
      check($sformatf("to_w%0d_err", i), 32'(bus_err_o), 32'd0);
      tick();
    end
    settle();
    check("to_err", 32'(bus_err_o), 32'd1);
    check("to_req", 32'(bus_req_o), 32'd0);
    check("to_ddata", dbus_data_o, 32'h0);
    check("to_dstall", 32'(dbus_stallreq_o), 32'd0);
    tick();
    dbus_ce_i = 1'b0;
    settle();
    check("to_err_end", 32'(bus_err_o), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
